fetch_queue: RTL and testbench

//   Instruction fetch queue between the PC/instruction-memory fetch stage and decode.

---
 rtl/fetch_queue.sv | 97 +++++++++
 tb/tb_fetch_queue.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// Fetch queue: DEPTH-entry {pc, instr} FIFO between fetch and decode.
// Define FETCH_QUEUE_BYPASS_EN for a same-cycle empty-queue bypass.
module fetch_queue #(
  parameter int              DEPTH = 4,
  parameter int              XLEN  = 64,
  parameter int              ILEN  = 32,
  parameter logic [ILEN-1:0] NOP   = 32'h0000_0013
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     enq_valid,
  output logic                     enq_ready,
  input  logic [XLEN-1:0]          enq_pc,
  input  logic [ILEN-1:0]          enq_instr,
  output logic                     deq_valid,
  input  logic                     deq_ready,
  output logic [XLEN-1:0]          deq_pc,
  output logic [ILEN-1:0]          deq_instr,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [XLEN-1:0] pc_mem  [DEPTH];
  logic [ILEN-1:0] ins_mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [CW-1:0]   cnt;

  logic empty;
  logic byp;
  logic byp_take;
  logic enq_fire;
  logic deq_fire;

  assign empty     = (cnt == '0);
  assign enq_ready = (cnt != CW'(DEPTH));
  assign count     = cnt;

`ifdef FETCH_QUEUE_BYPASS_EN
  assign byp      = empty & enq_valid & ~flush;
  assign byp_take = byp & deq_ready;
`else
  assign byp      = 1'b0;
  assign byp_take = 1'b0;
`endif

  // A bypassed entry goes straight to decode and never occupies a slot
  assign enq_fire = enq_valid & enq_ready & ~byp_take;
  assign deq_fire = ~empty & deq_ready;

  assign deq_valid = ~empty | byp;

  always_comb begin
    deq_pc    = '0;
    deq_instr = NOP;
    if (!empty) begin
      deq_pc    = pc_mem[rd_ptr];
      deq_instr = ins_mem[rd_ptr];
    end else if (byp) begin
      deq_pc    = enq_pc;
      deq_instr = enq_instr;
    end
  end

  always_ff @(posedge clk) begin
    if (enq_fire && !flush) begin
      pc_mem[wr_ptr]  <= enq_pc;
      ins_mem[wr_ptr] <= enq_instr;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (enq_fire)
        wr_ptr <= wr_ptr + AW'(1);
      if (deq_fire)
        rd_ptr <= rd_ptr + AW'(1);
      unique case ({enq_fire, deq_fire})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: directed steps plus random traffic
// against a queue-based reference model.
module tb_fetch_queue;

  localparam int DEPTH = 4;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        enq_valid = 1'b0;
  logic        enq_ready;
  logic [63:0] enq_pc = '0;
  logic [31:0] enq_instr = '0;
  logic        deq_valid;
  logic        deq_ready = 1'b0;
  logic [63:0] deq_pc;
  logic [31:0] deq_instr;
  logic [2:0]  count;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [63:0] pc;
    logic [31:0] ins;
  } ent_t;

  ent_t q[$];

  fetch_queue #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .enq_valid (enq_valid),
    .enq_ready (enq_ready),
    .enq_pc    (enq_pc),
    .enq_instr (enq_instr),
    .deq_valid (deq_valid),
    .deq_ready (deq_ready),
    .deq_pc    (deq_pc),
    .deq_instr (deq_instr),
    .count     (count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One cycle: drive, check outputs in low phase, clock, advance model
  task automatic step(input bit f, input bit ev, input bit dr,
                      input logic [63:0] pc, input logic [31:0] ins);
    bit byp;
    bit en;
    bit de;
    ent_t e;
    flush     = f;
    enq_valid = ev;
    deq_ready = dr;
    enq_pc    = pc;
    enq_instr = ins;
    #1;
    byp = 1'b0;
`ifdef FETCH_QUEUE_BYPASS_EN
    byp = (q.size() == 0) && ev && !f;
`endif
    chk("count", 64'(count), 64'(q.size()));
    chk("enq_ready", 64'(enq_ready), 64'(q.size() < DEPTH));
    chk("deq_valid", 64'(deq_valid), 64'((q.size() != 0) || byp));
    if (q.size() != 0) begin
      chk("deq_pc", deq_pc, q[0].pc);
      chk("deq_instr", 64'(deq_instr), 64'(q[0].ins));
    end else if (byp) begin
      chk("deq_pc_byp", deq_pc, pc);
      chk("deq_instr_byp", 64'(deq_instr), 64'(ins));
    end else begin
      chk("deq_pc_empty", deq_pc, 64'h0);
      chk("deq_instr_nop", 64'(deq_instr), 64'(NOP));
    end
    @(posedge clk);
    if (f) begin
      q.delete();
    end else if (!(byp && dr)) begin
      en = ev && (q.size() < DEPTH);
      de = dr && (q.size() > 0);
      if (de) void'(q.pop_front());
      if (en) begin
        e.pc  = pc;
        e.ins = ins;
        q.push_back(e);
      end
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    enq_valid = 1'b0;
    deq_ready = 1'b0;
    flush     = 1'b0;
    rst_n     = 1'b0;
    #1;
    chk("rst_count", 64'(count), 64'h0);
    chk("rst_deq_valid", 64'(deq_valid), 64'h0);
    chk("rst_enq_ready", 64'(enq_ready), 64'h1);
    chk("rst_deq_instr", 64'(deq_instr), 64'h13);
    chk("rst_deq_pc", deq_pc, 64'h0);
    q.delete();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    @(negedge clk);
    do_reset();

    // Fill to capacity
    for (int i = 0; i < 4; i++)
      step(0, 1, 0, 64'(4 * i), 32'h1000 + 32'(i));
    step(0, 0, 0, 64'h0, 32'h0);
    chk("full_count", 64'(count), 64'h4);
    chk("full_enq_ready", 64'(enq_ready), 64'h0);
    chk("full_head_pc", deq_pc, 64'h0);

    // Enqueue offered while full with a dequeue: must be refused
    step(0, 1, 1, 64'hdead, 32'hdead);
    step(0, 0, 0, 64'h0, 32'h0);

    // Drain, then deq_ready on empty is ignored
    for (int i = 0; i < 4; i++)
      step(0, 0, 1, 64'h0, 32'h0);
    step(0, 0, 1, 64'h0, 32'h0);
    step(0, 0, 0, 64'h0, 32'h0);

    // Steady state with wrap-around
    for (int i = 0; i < 10; i++)
      step(0, 1, 1, 64'h100 + 64'(4 * i), 32'h2000 + 32'(i));
    step(0, 0, 1, 64'h0, 32'h0);
    step(0, 0, 1, 64'h0, 32'h0);

    // Flush with a concurrent enqueue
    for (int i = 0; i < 3; i++)
      step(0, 1, 0, 64'h300 + 64'(4 * i), 32'h3000 + 32'(i));
    step(1, 1, 1, 64'h3ff0, 32'h3ff0);
    step(0, 0, 0, 64'h0, 32'h0);
    chk("flush_count", 64'(count), 64'h0);
    chk("flush_deq_valid", 64'(deq_valid), 64'h0);

    // Bypass / one-cycle latency on empty queue
    step(0, 1, 1, 64'h200, 32'h4000);
    step(0, 0, 0, 64'h0, 32'h0);
    step(0, 0, 1, 64'h0, 32'h0);
    step(0, 1, 0, 64'h204, 32'h4004);
    step(0, 0, 1, 64'h0, 32'h0);

    // Random traffic with rare flushes and one mid-traffic reset
    for (int i = 0; i < 400; i++) begin
      if (i == 200) begin
        step(0, 1, 0, 64'h9000, 32'h9000);
        do_reset();
      end
      step(($urandom_range(0, 19) == 0),
           1'($urandom_range(0, 2) != 0),
           1'($urandom_range(0, 1)),
           {32'($urandom), 32'($urandom)},
           32'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
